// File: rtl/window_3x3_generator.sv
// Purpose : builds a 3x3 RGB444 neighbourhood around each interior pixel of a raster-scanned frame.
// Latency : window for centre (x-1,y-1) is registered one cycle after pixel (x,y) is accepted.
// Backpressure: none; every accepted pixel is consumed in one cycle, idle cycles freeze all state.
//
// Ports:
//   clk, reset                  - single clock, synchronous active-high reset
//   pixel_in[11:0], pixel_valid - RGB444 pixel stream (R[11:8] G[7:4] B[3:0])
//   frame_start                 - marks the accepted pixel as (0,0); also (re)starts a frame
//   color_data[107:0]           - {centre,left,right,up,down,upleft,upright,downleft,downright}
//   window_valid, window_x/y    - single-cycle qualifier and centre coordinate
//   frame_done                  - single-cycle pulse after the last pixel of a frame
module window_3x3_generator #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [11:0]  pixel_in,
    input  logic         pixel_valid,
    input  logic         frame_start,
    output logic [107:0] color_data,
    output logic         window_valid,
    output logic [9:0]   window_x,
    output logic [9:0]   window_y,
    output logic         frame_done
);

    localparam int         AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [9:0] X_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t      state;
    logic [9:0]  col;
    logic [9:0]  row;

    // Row y-1 and row y-2 line buffers.
    logic [11:0] line1 [0:IMG_WIDTH-1];
    logic [11:0] line2 [0:IMG_WIDTH-1];

    // The two most recent window columns, index [row][col]; row 0 = y-2, col 1 = newest.
    // The third (oldest) column only exists inside next_win, because once shifted out
    // it is captured in color_data and never needed again.
    logic [2:0][1:0][11:0] hist;
    logic [2:0][2:0][11:0] next_win;

    logic        accept;
    logic        emit;
    logic        last_pix;
    logic [9:0]  cur_x;
    logic [9:0]  cur_y;
    logic [AW-1:0] addr;
    logic [11:0] up1;
    logic [11:0] up2;

    // A frame_start pixel is accepted from any state and is always (0,0), which is
    // what makes mid-frame restarts and back-to-back frames fall out naturally.
    assign accept   = pixel_valid && (frame_start || state == ACTIVE);
    assign cur_x    = frame_start ? 10'd0 : col;
    assign cur_y    = frame_start ? 10'd0 : row;
    assign addr     = cur_x[AW-1:0];
    assign up1      = line1[addr];
    assign up2      = line2[addr];
    // x>=2 guarantees both older columns belong to the current row, and y>=2
    // guarantees the line buffers hold rows of the current frame.
    assign emit     = accept && (cur_x >= 10'd2) && (cur_y >= 10'd2);
    assign last_pix = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);

    always_comb begin
        next_win = '0;
        for (int r = 0; r < 3; r++) begin
            next_win[r][0] = hist[r][0];
            next_win[r][1] = hist[r][1];
        end
        next_win[0][2] = up2;
        next_win[1][2] = up1;
        next_win[2][2] = pixel_in;
    end

    // Line buffers need no reset: stale contents are never emitted.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            line2[addr] <= up1;
            line1[addr] <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            hist         <= '0;
            color_data   <= '0;
            window_valid <= 1'b0;
            window_x     <= '0;
            window_y     <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    hist[r][0] <= next_win[r][1];
                    hist[r][1] <= next_win[r][2];
                end
                if (cur_x == X_LAST) begin
                    col <= '0;
                    row <= (cur_y == Y_LAST) ? 10'd0 : cur_y + 10'd1;
                end else begin
                    col <= cur_x + 10'd1;
                    row <= cur_y;
                end
                if (emit) begin
                    color_data   <= {next_win[1][1], next_win[1][0], next_win[1][2],
                                     next_win[0][1], next_win[2][1], next_win[0][0],
                                     next_win[0][2], next_win[2][0], next_win[2][2]};
                    window_valid <= 1'b1;
                    window_x     <= cur_x - 10'd1;
                    window_y     <= cur_y - 10'd1;
                end
                if (last_pix) begin
                    frame_done <= 1'b1;
                    state      <= DONE;
                end else begin
                    state      <= ACTIVE;
                end
            end
        end
    end

endmodule

// File: doc/window_3x3_generator.md
WINDOW_3X3_GENERATOR -- requirements
Module: window_3x3_generator

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, meaning pixels per line (legal range 3..1024).
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, meaning lines per frame (legal range 3..1024).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pixel_in, input, 12 bits: RGB444 pixel, with R in [11:8], G in [7:4] and B in [3:0].
REQ-006 SHALL have port pixel_valid, input, 1 bit: pixel_in is accepted in every cycle where this bit is high.
REQ-007 SHALL have port frame_start, input, 1 bit: qualified by pixel_valid; marks the accepted pixel as coordinate (0,0).
REQ-008 SHALL have port color_data, output, 108 bits: the 3x3 window.
REQ-009 SHALL have port window_valid, output, 1 bit: single-cycle qualifier for color_data, window_x and window_y.
REQ-010 SHALL have port window_x, output, 10 bits: column of the window centre.
REQ-011 SHALL have port window_y, output, 10 bits: row of the window centre.
REQ-012 SHALL have port frame_done, output, 1 bit: single-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-013 SHALL pack color_data as follows: centre [107:96], left [95:84], right [83:72], up [71:60], down [59:48], upleft [47:36], upright [35:24], downleft [23:12], downright [11:0].
REQ-014 SHALL track the coordinate (x,y) of the next accepted pixel with a column counter (wraps from IMG_WIDTH-1 to 0) and a row counter (increments when the column counter wraps).
REQ-015 SHALL keep two line buffers, each IMG_WIDTH x 12 bits, holding rows y-1 and y-2; on acceptance of pixel (x,y), the row y-1 entry at x moves to the row y-2 buffer and pixel_in is written to the row y-1 buffer at x.
REQ-016 SHALL keep a 3x3 register window; on each accepted pixel, the columns shift toward the left and the new right column is {row y-2[x], row y-1[x], pixel_in}.
REQ-017 SHALL, when pixel (x,y) with x>=2 and y>=2 is accepted, present the window centred at (x-1,y-1) on the next cycle, with window_valid=1, window_x=x-1, window_y=y-1.
REQ-018 SHALL emit exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame, interior only; no window is emitted for border centres.
REQ-019 SHALL NOT include columns left over from the previous row in any emitted window (this follows from the x>=2 condition in REQ-017).
REQ-020 SHALL, in cycles where pixel_valid=0, leave the counters, buffers and window unchanged, drive window_valid=0, and hold color_data, window_x and window_y at their last values.
REQ-021 SHALL, on accepting the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1), pulse frame_done on the next cycle (the same cycle as the final window_valid) and enter state DONE.
REQ-022 SHALL use states IDLE, ACTIVE and DONE: IDLE->ACTIVE on pixel_valid&frame_start; ACTIVE->DONE on the last pixel; DONE->ACTIVE on pixel_valid&frame_start.
REQ-023 SHALL ignore pixels with pixel_valid=1 and frame_start=0 while in IDLE or DONE: no counter change, no buffer write, no output.
REQ-024 SHALL, on frame_start in ACTIVE (mid-frame restart), treat that pixel as (0,0) and suppress all window output until the new frame reaches x>=2 and y>=2.
REQ-025 SHALL support back-to-back frames, i.e. frame_start in the cycle immediately after the last pixel, with no lost pixel.
REQ-026 SHALL have no backpressure; every valid pixel in ACTIVE, or every valid pixel carrying frame_start, is consumed in one cycle.

Reset
REQ-027 SHALL, in a cycle with reset=1, set state to IDLE, counters to 0, color_data to 0, window_valid to 0, window_x and window_y to 0, and frame_done to 0; reset overrides pixel_valid in the same cycle.
REQ-028 SHALL NOT require line-buffer contents to be cleared by reset, because stale data is never emitted (REQ-017, REQ-024).

Verification
REQ-029 SHALL cover reset: hold reset for 3 cycles with pixel_valid=1 -> all outputs 0 and no window_valid.
REQ-030 SHALL cover a ramp frame: IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = y*5+x, continuous valid -> 6 windows; the first (1,1) has color_data = centre 0x006, left 0x005, right 0x007, up 0x001, down 0x00B, upleft 0x000, upright 0x002, downleft 0x00A, downright 0x00C; frame_done asserts with window (3,2).
REQ-031 SHALL cover gaps: repeat REQ-030 with pixel_valid low 1 cycle in 3 -> identical window sequence, each window one cycle after its completing pixel.
REQ-032 SHALL cover mid-frame restart: frame_start at pixel (2,2) -> no window until new (2,2), which yields window (1,1) from the new data only.
REQ-033 SHALL cover post-frame and reset-mid-frame cases: 10 extra valid pixels after frame_done without frame_start -> no outputs; then reset mid-frame followed by a new frame -> output matches REQ-030 exactly.
